// File: rtl/cam_pixel_capture.sv
// OV7670 parallel-bus capture: packs byte pairs into RGB565 pixels and feeds
// the camera FIFO with a start marker per frame. Malformed lines/frames are
// flagged and FIFO overflow drops the rest of the frame so the downstream
// uploader only ever sees whole, aligned frames.
module cam_pixel_capture #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             capture_en,
    input  logic             cam_vsync,
    input  logic             cam_href,
    input  logic [7:0]       cam_data,
    input  logic             fifo_full,
    output logic [16:0]      fifo_data,
    output logic             fifo_wr_en,
    output logic             frame_done,
    output logic             frame_err,
    output logic             overflow,
    output logic [CNT_W-1:0] frame_count
);

    localparam int PIX_W  = $clog2(FRAME_WIDTH + 1);
    localparam int LINE_W = $clog2(FRAME_HEIGHT + 1);
    localparam logic [16:0]      MARKER = 17'h10000;
    localparam logic [PIX_W-1:0]  WIDTH_MAX  = PIX_W'(FRAME_WIDTH);
    localparam logic [LINE_W-1:0] HEIGHT_MAX = LINE_W'(FRAME_HEIGHT);

    typedef enum logic [2:0] {
        IDLE, WAIT_FALL, START, ACTIVE, DONE, DROP
    } state_t;

    state_t state_reg, state_next;

    // Registered copies of the camera bus plus one cycle of history
    logic        vsync_reg, href_reg, vsync_prev_reg, href_eff_prev_reg;
    logic [7:0]  data_reg;

    // Frame bookkeeping
    logic              phase_reg, phase_next;       // 0: expecting high byte
    logic [7:0]        hi_reg, hi_next;
    logic [15:0]       pix_reg, pix_next;
    logic              pend_reg, pend_next;         // pixel write due this cycle
    logic [PIX_W-1:0]  line_pix_reg, line_pix_next;
    logic [LINE_W-1:0] line_cnt_reg, line_cnt_next;
    logic              geom_bad_reg, geom_bad_next;  // some line had wrong width
    logic              restart_reg, restart_next;    // DONE reached via vsync fall
    logic              frame_err_reg, frame_err_next;
    logic              overflow_reg, overflow_next;
    logic [CNT_W-1:0]  frame_count_reg, frame_count_next;

    logic vsync_rise, vsync_fall, href_eff, line_end, err_final, full_hit;

    // href is only meaningful outside vertical blanking
    assign href_eff   = href_reg & ~vsync_reg;
    assign vsync_rise = vsync_reg & ~vsync_prev_reg;
    assign vsync_fall = ~vsync_reg & vsync_prev_reg;
    assign line_end   = href_eff_prev_reg & ~href_eff;
    assign err_final  = frame_err_reg | geom_bad_reg | (line_cnt_reg != HEIGHT_MAX);

    assign frame_err   = frame_err_reg;
    assign overflow    = overflow_reg;
    assign frame_count = frame_count_reg;

    // Input register stage: everything downstream uses these copies
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_reg         <= 1'b0;
            href_reg          <= 1'b0;
            data_reg          <= 8'h00;
            vsync_prev_reg    <= 1'b0;
            href_eff_prev_reg <= 1'b0;
        end else begin
            vsync_reg         <= cam_vsync;
            href_reg          <= cam_href;
            data_reg          <= cam_data;
            vsync_prev_reg    <= vsync_reg;
            href_eff_prev_reg <= href_eff;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // Pixel assembly and frame bookkeeping registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_reg       <= 1'b0;
            hi_reg          <= 8'h00;
            pix_reg         <= 16'h0000;
            pend_reg        <= 1'b0;
            line_pix_reg    <= '0;
            line_cnt_reg    <= '0;
            geom_bad_reg    <= 1'b0;
            restart_reg     <= 1'b0;
            frame_err_reg   <= 1'b0;
            overflow_reg    <= 1'b0;
            frame_count_reg <= '0;
        end else begin
            phase_reg       <= phase_next;
            hi_reg          <= hi_next;
            pix_reg         <= pix_next;
            pend_reg        <= pend_next;
            line_pix_reg    <= line_pix_next;
            line_cnt_reg    <= line_cnt_next;
            geom_bad_reg    <= geom_bad_next;
            restart_reg     <= restart_next;
            frame_err_reg   <= frame_err_next;
            overflow_reg    <= overflow_next;
            frame_count_reg <= frame_count_next;
        end
    end

    // Next-state, bookkeeping updates and FIFO-side outputs
    always_comb begin
        state_next       = state_reg;
        phase_next       = phase_reg;
        hi_next          = hi_reg;
        pix_next         = pix_reg;
        pend_next        = 1'b0;
        line_pix_next    = line_pix_reg;
        line_cnt_next    = line_cnt_reg;
        geom_bad_next    = geom_bad_reg;
        restart_next     = restart_reg;
        frame_err_next   = frame_err_reg;
        overflow_next    = overflow_reg;
        frame_count_next = frame_count_reg;
        fifo_data        = {1'b0, pix_reg};
        fifo_wr_en       = 1'b0;
        frame_done       = 1'b0;
        full_hit         = 1'b0;

        case (state_reg)
            IDLE: begin
                // Only arm during blanking so a frame is never joined mid-way
                if (capture_en && vsync_reg) state_next = WAIT_FALL;
            end
            WAIT_FALL: begin
                if (vsync_fall) state_next = START;
            end
            START: begin
                restart_next  = 1'b0;
                phase_next    = 1'b0;
                line_pix_next = '0;
                line_cnt_next = '0;
                geom_bad_next = 1'b0;
                if (!fifo_full) begin
                    fifo_data      = MARKER;
                    fifo_wr_en     = 1'b1;
                    frame_err_next = 1'b0;
                    overflow_next  = 1'b0;
                    state_next     = ACTIVE;
                end else begin
                    overflow_next = 1'b1;
                    state_next    = DROP;
                end
            end
            ACTIVE: begin
                if (pend_reg) begin
                    if (fifo_full) full_hit   = 1'b1;
                    else           fifo_wr_en = 1'b1;
                end
                if (full_hit) begin
                    // Lost a pixel: abandon the rest of this frame
                    overflow_next = 1'b1;
                    if (vsync_rise) begin
                        frame_done = 1'b1;
                        state_next = capture_en ? WAIT_FALL : IDLE;
                    end else begin
                        state_next = DROP;
                    end
                end else begin
                    if (line_end) begin
                        if (phase_reg) frame_err_next = 1'b1;
                        phase_next = 1'b0;
                        if (line_pix_reg != '0) begin
                            line_cnt_next = line_cnt_reg + LINE_W'(1);
                            if (line_pix_reg != WIDTH_MAX) geom_bad_next = 1'b1;
                        end
                        line_pix_next = '0;
                    end
                    if (href_eff && !vsync_fall) begin
                        if (!phase_reg) begin
                            hi_next    = data_reg;
                            phase_next = 1'b1;
                        end else begin
                            phase_next = 1'b0;
                            if (line_cnt_reg >= HEIGHT_MAX || line_pix_reg >= WIDTH_MAX) begin
                                frame_err_next = 1'b1;
                            end else begin
                                pix_next      = {hi_reg, data_reg};
                                pend_next     = 1'b1;
                                line_pix_next = line_pix_reg + PIX_W'(1);
                            end
                        end
                    end
                    if (vsync_rise) begin
                        state_next = DONE;
                    end else if (vsync_fall) begin
                        // Missed the rise: close this frame, then start anew
                        state_next   = DONE;
                        restart_next = 1'b1;
                    end
                end
            end
            DONE: begin
                frame_done     = 1'b1;
                frame_err_next = err_final;
                if (!err_final) frame_count_next = frame_count_reg + CNT_W'(1);
                if (!capture_en)      state_next = IDLE;
                else if (restart_reg) state_next = START;
                else                  state_next = WAIT_FALL;
                restart_next = 1'b0;
            end
            DROP: begin
                if (vsync_rise) begin
                    frame_done = 1'b1;
                    state_next = capture_en ? WAIT_FALL : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/cam_pixel_capture.md
Name: cam_pixel_capture

Overview:
- Upstream stage of the video frame buffer path.
- Samples the OV7670 parallel bus (vsync, href, 8-bit data), packs byte pairs into 16-bit RGB565 pixels, and pushes 17-bit words into the camera FIFO.
- Each frame is prefixed with a start marker word 17'h10000; pixel words carry bit16=0.
- Polices frame geometry and FIFO overflow so the downstream uploader always receives whole, aligned frames.

Parameters:
- FRAME_WIDTH, 640, active pixels per line (2 bytes each).
- FRAME_HEIGHT, 480, active lines per frame.
- CNT_W, 16, width of the frame counter.

Ports:
- clk  input  1  camera pixel clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- capture_en  input  1  enable; sampled only at frame boundaries.
- cam_vsync  input  1  frame sync; high = vertical blanking.
- cam_href  input  1  line valid; high = active bytes.
- cam_data  input  8  pixel byte; high byte of pixel first.
- fifo_full  input  1  camera FIFO full.
- fifo_data  output  17  {marker, pixel[15:0]}.
- fifo_wr_en  output  1  one-cycle FIFO write strobe.
- frame_done  output  1  one-cycle pulse at end of a captured frame.
- frame_err  output  1  sticky geometry error for the current or last frame.
- overflow  output  1  sticky; last frame dropped because of fifo_full.
- frame_count  output  CNT_W  completed good frames; wraps modulo 2^CNT_W.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, byte phase 0.
- Input register: cam_vsync, cam_href, cam_data are registered once. All logic uses the registered copies. vsync_fall and vsync_rise are edge detects on the registered vsync.
- States:
  - IDLE: leave when capture_en=1 and registered vsync=1 → WAIT_FALL. A frame is never entered mid-way.
  - WAIT_FALL: on vsync_fall → START.
  - START: one cycle. If fifo_full=0: drive fifo_data=17'h10000, fifo_wr_en=1, clear frame_err, overflow, line count and pixel count → ACTIVE. If fifo_full=1: set overflow → DROP, no write.
  - ACTIVE:
    - While registered href=1, bytes alternate high/low. On each low byte, emit {1'b0, hi, lo} with fifo_wr_en=1 in the next cycle. This gives latency 2 clk edges from the low byte on cam_data to the fifo_wr_en cycle.
    - Falling href ends a line: line count increments if ≥1 pixel was captured in it. An odd trailing byte is discarded and sets frame_err.
    - Pixels beyond FRAME_WIDTH in a line: discarded, frame_err set.
    - Lines beyond FRAME_HEIGHT: discarded, frame_err set.
    - fifo_full=1 at any point where a write is due: that write is suppressed, overflow set → DROP.
    - vsync_rise → DONE.
  - DONE: one cycle.
    - If line count != FRAME_HEIGHT, or any line had a pixel count != FRAME_WIDTH: set frame_err.
    - Always pulse frame_done.
    - If frame_err=0, increment frame_count.
    - Next state: → WAIT_FALL if capture_en=1, else IDLE.
  - DROP: no writes. On vsync_rise, pulse frame_done (frame_count unchanged) → WAIT_FALL or IDLE per capture_en. A dropped frame is never resumed; the next frame starts with a fresh marker.
- Boundary rules:
  - fifo_wr_en is never asserted while fifo_full=1.
  - The marker is written only in START.
  - capture_en falling mid-frame does not abort the frame; it takes effect at DONE or DROP exit.
  - vsync_fall while in ACTIVE (no rise seen) is treated as vsync_rise followed by an immediate new frame: DONE logic runs, then START.
  - href while registered vsync=1 is ignored.
  - Reset asserted mid-frame: immediate return to IDLE, no further writes.
- frame_count wraps 2^CNT_W-1 → 0.

Test Plan:
- FRAME_WIDTH=23, FRAME_HEIGHT=17; send 5 random frames with fifo_full=0 → each frame gives 17'h10000 followed by 391 pixel words in order; 5 frame_done pulses; frame_count=5; frame_err=0.
- Bytes 0xAB, 0xCD at href start → first pixel word 17'h0ABCD; fifo_wr_en 2 edges after 0xCD is presented.
- Assert fifo_full for 1 cycle during line 3 → overflow=1, no writes until next vsync. Next frame: fresh marker, 391 words, overflow cleared at START, frame_count increments only for the good frame.
- Line of 24 pixels and a frame of 16 lines → extra pixel not written, frame_err=1 at DONE, frame_count unchanged.
- 47 bytes on one line (odd) → 23 pixels written, frame_err=1.
- capture_en raised while vsync=0 mid-frame → no writes until the next full vsync high-then-low; reset_n pulsed mid-frame → all outputs 0 and state IDLE immediately.
